mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter (see REQ-030).
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 opcode  input  6  instruction-register bits [31:26]; sampled in every state.
REQ-005 zero  input  1  ALU zero flag (1 when ALU result == 0).
REQ-006 pc_wre, ir_wre, reg_wre, mem_rd, mem_wr  output  1 each  PC/IR/register-file write enables; data-memory read/write strobes.
REQ-007 alu_src_a  output  1  1 selects zero-extended shamt for ALU A; 0 selects rs.
REQ-008 alu_src_b  output  1  1 selects extended immediate for ALU B; 0 selects rt.
REQ-009 alu_op  output  3  ALU code: 000 add, 001 sub, 010 set-if-A<B, 011 srl, 100 sll, 101 or, 110 and, 111 xor.
REQ-010 db_src, reg_dst, ext_sel  output  1 each  write-back source (1 = memory); destination (1 = rd, 0 = rt); immediate extension (1 = sign, 0 = zero).
REQ-011 pc_src  output  2  next PC: 00 PC+4, 01 branch target, 10 jump target.
REQ-012 state  output  3  current FSM state code; halted  output  1  high in HALT.

Function
REQ-013 Opcode table SHALL be: add 000000/000, sub 000001/001, addi 000010/000, or 010000/101, and 010001/110, ori 010010/101, sll 011000/100, slt 100111/010, sw 110000/000, lw 110001/000, beq 110100/001, j 111000, halt 111111 (opcode/alu_op).
REQ-014 FSM states SHALL be IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111; state transitions occur only on the clk rising edge.
REQ-015 IF->ID unconditionally; ir_wre = 1 in IF only.
REQ-016 ID: j -> IF; halt -> HALT; any opcode not in REQ-013 -> IF (treated as nop); otherwise -> EXE.
REQ-017 EXE: beq -> IF; sw/lw -> MEM; all other opcodes -> WB.
REQ-018 MEM: sw -> IF; lw -> WB. WB -> IF. HALT -> HALT until reset.
REQ-019 pc_wre SHALL be 1 for exactly one cycle per instruction, in its final state: ID for j/nop, EXE for beq, MEM for sw, WB otherwise; 0 in HALT.
REQ-020 pc_src SHALL be 10 for j; 01 for beq when zero = 1 during EXE; 00 for beq when zero = 0 and for all other instructions.
REQ-021 alu_op, alu_src_a, alu_src_b and ext_sel SHALL be held constant from ID through the instruction's final state.
REQ-022 alu_src_b = 1 for addi, ori, sw, lw; alu_src_a = 1 for sll only; ext_sel = 0 for ori, 1 for all other opcodes.
REQ-023 reg_wre = 1 only in WB; reg_dst = 0 for addi/ori/lw; db_src = 1 for lw only.
REQ-024 mem_wr = 1 only in MEM for sw; mem_rd = 1 only in MEM for lw; mem_rd and mem_wr SHALL never both be 1.
REQ-025 All outputs SHALL be decoded combinationally from the state register and opcode (Moore per instruction); an opcode change mid-instruction is undefined, since the IR is stable while ir_wre = 0.

Reset
REQ-026 rst_n low SHALL force state = IF asynchronously, including mid-instruction; the FSM restarts at IF on the first clk edge after release.
REQ-027 While rst_n is low, all enables and strobes SHALL be 0, alu_op = 000, pc_src = 00, halted = 0.
REQ-028 Reset SHALL be the only exit from HALT.

Configuration
REQ-029 Macro MC_CTRL_PERF_EN SHALL enable a retired-instruction counter.
REQ-030 With MC_CTRL_PERF_EN defined: output instr_cnt [CNT_W-1:0], cleared by reset; increments on each cycle with pc_wre = 1; wraps from all-ones to 0; does not increment in HALT.
REQ-031 Without MC_CTRL_PERF_EN: no instr_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-032 add (000000) after reset -> states IF,ID,EXE,WB,IF; reg_wre = 1, reg_dst = 1, alu_op = 000 in WB; pc_wre = 1 only in WB.
REQ-033 lw (110001) -> IF,ID,EXE,MEM,WB; mem_rd = 1 in MEM, db_src = 1 in WB; sw (110000) -> IF,ID,EXE,MEM with mem_wr = 1, then IF.
REQ-034 beq with zero = 1 -> pc_src = 01 and pc_wre = 1 in EXE; with zero = 0 -> pc_src = 00; both return to IF with reg_wre never 1.
REQ-035 j -> pc_src = 10 and pc_wre = 1 in ID; opcode 101010 (unlisted) -> IF,ID,IF with reg_wre, mem_wr = 0 throughout.
REQ-036 halt -> state = 111 and halted = 1 held for 10 cycles; rst_n pulsed low mid-EXE of an add -> state = 000 immediately with reg_wre = 0.
REQ-037 PERF build with CNT_W = 4: 16 retired add instructions -> instr_cnt = 0 (wrap); after a further halt -> instr_cnt = 1 and then constant.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU controller: IF/ID/EXE/MEM/WB/HALT sequencing with Moore-style decode.
// Define MC_CTRL_PERF_EN to add the retired-instruction counter output instr_cnt.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_wre,
    output logic       ir_wre,
    output logic       reg_wre,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic       db_src,
    output logic       reg_dst,
    output logic       ext_sel,
    output logic [1:0] pc_src,
    output logic [2:0] state,
    output logic       halted
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_valid;
    logic [2:0] w_alu_op;
    logic       w_src_a;
    logic       w_src_b;
    logic       w_ext;
    logic       w_rt_dst;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_is_j;
    logic       w_is_halt;
    logic       w_active;

    generate
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("mc_ctrl: CNT_W must be at least 1");
        end
    endgenerate

    always_comb begin
        w_valid   = 1'b1;
        w_alu_op  = 3'b000;
        w_src_a   = 1'b0;
        w_src_b   = 1'b0;
        w_ext     = 1'b1;
        w_rt_dst  = 1'b0;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
        w_is_beq  = 1'b0;
        w_is_j    = 1'b0;
        w_is_halt = 1'b0;
        case (opcode)
            6'b000000: ;
            6'b000001: w_alu_op = 3'b001;
            6'b000010: begin w_src_b = 1'b1; w_rt_dst = 1'b1; end
            6'b010000: w_alu_op = 3'b101;
            6'b010001: w_alu_op = 3'b110;
            6'b010010: begin w_alu_op = 3'b101; w_src_b = 1'b1; w_ext = 1'b0; w_rt_dst = 1'b1; end
            6'b011000: begin w_alu_op = 3'b100; w_src_a = 1'b1; end
            6'b100111: w_alu_op = 3'b010;
            6'b110000: begin w_src_b = 1'b1; w_is_sw = 1'b1; end
            6'b110001: begin w_src_b = 1'b1; w_rt_dst = 1'b1; w_is_lw = 1'b1; end
            6'b110100: begin w_alu_op = 3'b001; w_is_beq = 1'b1; end
            6'b111000: w_is_j = 1'b1;
            6'b111111: w_is_halt = 1'b1;
            default:   w_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IF;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF:    w_next = S_ID;
            S_ID: begin
                if (w_is_j || !w_valid) w_next = S_IF;
                else if (w_is_halt)     w_next = S_HALT;
                else                    w_next = S_EXE;
            end
            S_EXE: begin
                if (w_is_beq)               w_next = S_IF;
                else if (w_is_lw || w_is_sw) w_next = S_MEM;
                else                        w_next = S_WB;
            end
            S_MEM:   w_next = w_is_lw ? S_WB : S_IF;
            S_WB:    w_next = S_IF;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    assign w_active = (r_state == S_ID) || (r_state == S_EXE) ||
                      (r_state == S_MEM) || (r_state == S_WB);

    always_comb begin
        pc_wre    = 1'b0;
        reg_wre   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        pc_src    = 2'b00;
        alu_op    = 3'b000;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b0;
        reg_dst   = 1'b0;
        db_src    = 1'b0;
        // IR is stable from ID onward, so ALU controls hold for the rest of the instruction
        if (w_active) begin
            alu_op    = w_alu_op;
            alu_src_a = w_src_a;
            alu_src_b = w_src_b;
            ext_sel   = w_ext;
            reg_dst   = ~w_rt_dst;
            db_src    = w_is_lw;
        end
        case (r_state)
            S_ID: begin
                pc_wre = w_is_j || w_is_halt || !w_valid;
                if (w_is_j) pc_src = 2'b10;
            end
            S_EXE: begin
                pc_wre = w_is_beq;
                if (w_is_beq && zero) pc_src = 2'b01;
            end
            S_MEM: begin
                mem_wr = w_is_sw;
                mem_rd = w_is_lw;
                pc_wre = w_is_sw;
            end
            S_WB: begin
                reg_wre = 1'b1;
                pc_wre  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset holds the FSM in IF, whose only asserted output is ir_wre
    assign ir_wre = (r_state == S_IF) && rst_n;
    assign state  = r_state;
    assign halted = (r_state == S_HALT);

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_instr_cnt <= '0;
        else if (pc_wre) r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: instruction-level model of state paths and control outputs,
// directed opcode sequence, reset/HALT scenarios and (PERF build) counter wrap.
module tb_mc_ctrl;

    localparam int K_ALU  = 0;
    localparam int K_LW   = 1;
    localparam int K_SW   = 2;
    localparam int K_BEQ  = 3;
    localparam int K_J    = 4;
    localparam int K_HALT = 5;
    localparam int K_NOP  = 6;

    typedef struct packed {
        logic [5:0] op;
        logic [2:0] alu;
        logic       sa;
        logic       sb;
        logic       ext;
        logic       rdst;
        logic [2:0] kind;
    } ent_t;

    ent_t tbl [13] = '{
        '{6'b000000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0},
        '{6'b000001, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0},
        '{6'b000010, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0},
        '{6'b010000, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0},
        '{6'b010001, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0},
        '{6'b010010, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0},
        '{6'b011000, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0},
        '{6'b100111, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0},
        '{6'b110000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2},
        '{6'b110001, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1},
        '{6'b110100, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3},
        '{6'b111000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4},
        '{6'b111111, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5}
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_wre, ir_wre, reg_wre, mem_rd, mem_wr;
    logic       alu_src_a, alu_src_b, db_src, reg_dst, ext_sel, halted;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [3:0] instr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt   = 0;

    logic        e_valid = 1'b0;
    logic [2:0]  e_state;
    logic        e_ir, e_pc_wre, e_reg_wre, e_mem_rd, e_mem_wr, e_halted;
    logic [1:0]  e_pc_src;
    logic        e_chk_pc, e_ctl, e_wb;
    logic [2:0]  e_alu;
    logic        e_sa, e_sb, e_ext, e_rdst, e_dbsrc;
    logic [14:0] tr = '0;

    mc_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .pc_wre(pc_wre), .ir_wre(ir_wre), .reg_wre(reg_wre),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .db_src(db_src), .reg_dst(reg_dst), .ext_sel(ext_sel),
        .pc_src(pc_src), .state(state), .halted(halted)
`ifdef MC_CTRL_PERF_EN
        , .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int find(input logic [5:0] op);
        for (int i = 0; i < 13; i++)
            if (tbl[i].op == op) return i;
        return -1;
    endfunction

    function automatic int kind_of(input logic [5:0] op);
        int idx = find(op);
        return (idx < 0) ? K_NOP : int'(tbl[idx].kind);
    endfunction

    // States visited by one instruction, from IF to its final state
    function automatic int path_len(input int kind);
        case (kind)
            K_LW:              return 5;
            K_ALU, K_SW:       return 4;
            K_BEQ:             return 3;
            default:           return 2;
        endcase
    endfunction

    function automatic logic [2:0] path_state(input int kind, input int step);
        if (step < 2) return 3'(step);
        if (step == 2) return 3'b010;
        if (step == 3) return (kind == K_ALU) ? 3'b100 : 3'b011;
        return 3'b100;
    endfunction

    always @(negedge clk) begin
        if (e_valid) begin
            tr = {tr[11:0], state};
            chk("state", state, e_state);
            chk("ir_wre", ir_wre, e_ir);
            chk("pc_wre", pc_wre, e_pc_wre);
            chk("reg_wre", reg_wre, e_reg_wre);
            chk("mem_rd", mem_rd, e_mem_rd);
            chk("mem_wr", mem_wr, e_mem_wr);
            chk("halted", halted, e_halted);
            if (e_chk_pc) chk("pc_src", pc_src, e_pc_src);
            if (e_ctl) begin
                chk("alu_op", alu_op, e_alu);
                chk("alu_src_a", alu_src_a, e_sa);
                chk("alu_src_b", alu_src_b, e_sb);
                chk("ext_sel", ext_sel, e_ext);
            end
            if (e_wb) begin
                chk("reg_dst", reg_dst, e_rdst);
                chk("db_src", db_src, e_dbsrc);
            end
`ifdef MC_CTRL_PERF_EN
            chk("instr_cnt", instr_cnt, 32'(m_cnt % 16));
`endif
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_enables"}, {ir_wre, pc_wre, reg_wre, mem_rd, mem_wr}, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_pc_src"}, pc_src, 0);
        chk({tag, "_halted"}, halted, 0);
`ifdef MC_CTRL_PERF_EN
        chk({tag, "_cnt"}, instr_cnt, 0);
`endif
    endtask

    // Runs one instruction starting in IF at posedge+1; abort_at >= 0 resets mid-step
    task automatic run_instr(input string nm, input logic [5:0] op, input logic z,
                             input logic [14:0] exp_tr, input int abort_at);
        int idx  = find(op);
        int kind = kind_of(op);
        int n    = path_len(kind);
        logic [14:0] mask;
        opcode = op;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            e_state   = path_state(kind, i);
            e_ir      = (i == 0);
            e_pc_wre  = (i == n - 1);
            e_reg_wre = (e_state == 3'b100);
            e_mem_rd  = (e_state == 3'b011) && (kind == K_LW);
            e_mem_wr  = (e_state == 3'b011) && (kind == K_SW);
            e_halted  = 1'b0;
            e_chk_pc  = 1'b1;
            e_pc_src  = 2'b00;
            if (i == n - 1 && kind == K_J) e_pc_src = 2'b10;
            if (i == n - 1 && kind == K_BEQ && z) e_pc_src = 2'b01;
            e_ctl     = (i > 0) && (kind <= K_BEQ);
            e_wb      = (e_state == 3'b100);
            if (idx >= 0) begin
                e_alu  = tbl[idx].alu;
                e_sa   = tbl[idx].sa;
                e_sb   = tbl[idx].sb;
                e_ext  = tbl[idx].ext;
                e_rdst = tbl[idx].rdst;
            end
            e_dbsrc = (kind == K_LW);
            e_valid = 1'b1;
            if (i == abort_at) begin
                @(negedge clk);
                #2;
                rst_n   = 1'b0;
                e_valid = 1'b0;
                m_cnt   = 0;
                #1;
                chk_reset({nm, "_mid"});
                chk({nm, "_mid_reg_wre"}, reg_wre, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        e_valid = 1'b0;
        m_cnt++;
        mask = 15'((1 << (3 * n)) - 1);
        chk({nm, "_trace"}, tr & mask, exp_tr);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        chk("model_lw_len", path_len(kind_of(6'b110001)), 5);
        chk("model_j_len", path_len(kind_of(6'b111000)), 2);
        chk("model_nop_kind", kind_of(6'b101010), K_NOP);
        rst_n = 1'b1;

        run_instr("add",  6'b000000, 1'b0, 15'o0124,  -1);
        run_instr("lw",   6'b110001, 1'b0, 15'o01234, -1);
        run_instr("sw",   6'b110000, 1'b0, 15'o0123,  -1);
        run_instr("beq1", 6'b110100, 1'b1, 15'o012,   -1);
        run_instr("beq0", 6'b110100, 1'b0, 15'o012,   -1);
        run_instr("j",    6'b111000, 1'b0, 15'o01,    -1);
        run_instr("nop",  6'b101010, 1'b0, 15'o01,    -1);
        run_instr("addi", 6'b000010, 1'b0, 15'o0124,  -1);
        run_instr("or",   6'b010000, 1'b0, 15'o0124,  -1);
        run_instr("and",  6'b010001, 1'b0, 15'o0124,  -1);
        run_instr("ori",  6'b010010, 1'b1, 15'o0124,  -1);
        run_instr("sll",  6'b011000, 1'b0, 15'o0124,  -1);
        run_instr("slt",  6'b100111, 1'b0, 15'o0124,  -1);
        run_instr("sub",  6'b000001, 1'b1, 15'o0124,  -1);

        rst_n = 1'b0;
        m_cnt = 0;
        #1;
        chk_reset("rst2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++)
            run_instr("add16", 6'b000000, 1'b0, 15'o0124, -1);
`ifdef MC_CTRL_PERF_EN
        chk("cnt_wrap", instr_cnt, 0);
`endif
        run_instr("halt", 6'b111111, 1'b0, 15'o01, -1);
        for (int k = 0; k < 10; k++) begin
            opcode    = (k < 5) ? 6'b111111 : 6'b000000;
            e_state   = 3'b111;
            e_ir      = 1'b0;
            e_pc_wre  = 1'b0;
            e_reg_wre = 1'b0;
            e_mem_rd  = 1'b0;
            e_mem_wr  = 1'b0;
            e_halted  = 1'b1;
            e_chk_pc  = 1'b0;
            e_ctl     = 1'b0;
            e_wb      = 1'b0;
            e_valid   = 1'b1;
            @(posedge clk);
            #1;
        end
        e_valid = 1'b0;
        chk("halt_held_state", state, 3'b111);
`ifdef MC_CTRL_PERF_EN
        chk("cnt_after_halt", instr_cnt, 1);
`endif
        rst_n = 1'b0;
        m_cnt = 0;
        #1;
        chk_reset("halt_exit");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr("add_abort", 6'b000000, 1'b0, 15'o0124, 2);
        run_instr("add_after", 6'b000000, 1'b0, 15'o0124, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
